multiply_and_add: RTL and testbench
===================================

Name: multiply_and_add

Overview:
Unsigned multiply-accumulate datapath element: output = add_value + input_value × weight_value.
- Used as the per-cell arithmetic of the neural-network compute array.
- The running partial sum enters on add_value; the activation/weight product is added to it.
- Provides an immediate combinational result plus a one-cycle registered copy with valid and overflow indication, for pipelined chaining between cells.

Parameters:
- DATA_WIDTH, 8, width of input_value; accumulator/result width is 2*DATA_WIDTH.
- WEIGHT_WIDTH, 8, width of weight_value; must satisfy WEIGHT_WIDTH <= DATA_WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- add_value  input  2*DATA_WIDTH  incoming partial sum, unsigned.
- input_value  input  DATA_WIDTH  activation operand, unsigned.
- weight_value  input  WEIGHT_WIDTH  weight operand, unsigned.
- in_valid  input  1  qualifies operands for the registered stage.
- output_value  output  2*DATA_WIDTH  combinational result.
- out_valid  output  1  registered copy of in_valid.
- output_value_q  output  2*DATA_WIDTH  registered result.
- overflow_q  output  1  registered carry-out of the addition.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low.
- Clock port is clk; reset port is rst_n.

Combinational path:
- product = input_value × weight_value, unsigned, zero-extended to 2*DATA_WIDTH. It cannot overflow because WEIGHT_WIDTH <= DATA_WIDTH.
- output_value = (add_value + product) mod 2^(2*DATA_WIDTH).
- Purely combinational: it settles after any input change, needs no clock, and ignores in_valid and rst_n.
- Zero operands: output_value = add_value exactly.
  - input_value = 0 gives add_value.
  - weight_value = 0 gives add_value.

Carry:
- carry = bit 2*DATA_WIDTH of the (2*DATA_WIDTH+1)-bit sum add_value + product.

Registered path:
- While rst_n = 0 (asynchronous assertion): output_value_q = 0, overflow_q = 0, out_valid = 0.
- Deassertion takes effect at the next rising clk edge.
- At each rising edge with rst_n = 1:
  - out_valid <= in_valid.
  - If in_valid = 1: output_value_q <= output_value and overflow_q <= carry.
  - If in_valid = 0: output_value_q and overflow_q hold their previous values.
- Latency: exactly 1 cycle from sampled operands to output_value_q/out_valid.
- Throughput: one operation per cycle, no backpressure.
- Reset mid-operation: registered outputs clear immediately; any in-flight result is discarded. The combinational output_value is unaffected.
- No X propagation from reset: all registers have defined reset values.

Decomposition:
- Shared package (mlfpga_pkg): default DATA_WIDTH = 8 and WEIGHT_WIDTH = 8 constants, and a function/localparam for ACC_WIDTH = 2*DATA_WIDTH.
- Datapath is small; no sub-module is required.
- Optionally split the pure-combinational arithmetic into a leaf mac_comb (product + sum + carry). multiply_and_add then wraps mac_comb with the output register stage.

Test Plan:
- All inputs 0, in_valid=0 -> output_value=0.
  - After reset release, out_valid=0, output_value_q=0, overflow_q=0.
- add_value=1, input_value=0, weight_value=0 -> output_value=1.
  - Then input_value=2 (weight still 0) -> output_value=1.
  - Then weight_value=3 -> output_value=7 (combinational, within 10 ns, no clock edge needed).
- add_value=10, input_value=5, weight_value=2, in_valid=1 for one cycle:
  - output_value=20 immediately.
  - Next edge: output_value_q=20, out_valid=1, overflow_q=0.
  - Following edge with in_valid=0: out_valid=0, output_value_q stays 20.
- Wrap-around: add_value=16'hFFFF, input_value=1, weight_value=1, in_valid=1:
  - output_value=0.
  - Next edge: output_value_q=0, overflow_q=1.
- Max product: add_value=0, input_value=255, weight_value=255 -> output_value=65025, overflow_q=0 after the edge.
  - Then add_value=511 -> output_value=0 (65025+511=65536 wraps), overflow_q=1.
- Reset mid-stream: stream in_valid=1 with changing operands, assert rst_n=0 between clock edges:
  - output_value_q, overflow_q, out_valid go 0 without a clock edge.
  - output_value continues to track the inputs.
  - After release, the first edge with in_valid=1 registers the new result.

Source files
------------

// File: rtl/mlfpga_pkg.sv
// Shared constants for the ML compute-array datapath cells.
//   DATA_WIDTH_DEF   : default activation width
//   WEIGHT_WIDTH_DEF : default weight width (must not exceed the activation width)
//   acc_width()      : accumulator width derived from the activation width
package mlfpga_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int WEIGHT_WIDTH_DEF = 8;

  function automatic int acc_width(input int data_width);
    return 2 * data_width;
  endfunction

  localparam int ACC_WIDTH_DEF = acc_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/multiply_and_add_mac_comb.sv
// Pure-combinational multiply-accumulate leaf: sum = add_value + input_value * weight_value.
// Ports:
//   add_value    in  ACC_WIDTH     incoming partial sum
//   input_value  in  DATA_WIDTH    activation operand
//   weight_value in  WEIGHT_WIDTH  weight operand
//   sum          out ACC_WIDTH     result modulo 2^ACC_WIDTH
//   carry        out 1             carry-out of the addition
module mac_comb
  import mlfpga_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF,
  parameter int ACC_WIDTH    = acc_width(DATA_WIDTH)
) (
  input  logic [ACC_WIDTH-1:0]    add_value,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic [WEIGHT_WIDTH-1:0] weight_value,
  output logic [ACC_WIDTH-1:0]    sum,
  output logic                    carry
);

  logic [ACC_WIDTH-1:0] product;
  logic [ACC_WIDTH:0]   sum_full;

  // The product fits in ACC_WIDTH because the weight is never wider than the activation.
  always_comb begin
    product  = ACC_WIDTH'(input_value) * ACC_WIDTH'(weight_value);
    sum_full = {1'b0, add_value} + {1'b0, product};
  end

  assign sum   = sum_full[ACC_WIDTH-1:0];
  assign carry = sum_full[ACC_WIDTH];

endmodule

// File: rtl/multiply_and_add.sv
// Unsigned multiply-accumulate cell with combinational result and a one-cycle
// registered copy (valid + overflow) for pipelined chaining between cells.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   add_value       in  2*DATA_WIDTH  incoming partial sum
//   input_value     in  DATA_WIDTH    activation
//   weight_value    in  WEIGHT_WIDTH  weight
//   in_valid        in  1             qualifies operands for the register stage
//   output_value    out 2*DATA_WIDTH  combinational result
//   out_valid       out 1             registered in_valid
//   output_value_q  out 2*DATA_WIDTH  registered result (held when in_valid=0)
//   overflow_q      out 1             registered carry-out (held when in_valid=0)
module multiply_and_add
  import mlfpga_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int WEIGHT_WIDTH = WEIGHT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*DATA_WIDTH-1:0]      add_value,
  input  logic [DATA_WIDTH-1:0]        input_value,
  input  logic [WEIGHT_WIDTH-1:0]      weight_value,
  input  logic                         in_valid,
  output logic [2*DATA_WIDTH-1:0]      output_value,
  output logic                         out_valid,
  output logic [2*DATA_WIDTH-1:0]      output_value_q,
  output logic                         overflow_q
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH);

  if (WEIGHT_WIDTH > DATA_WIDTH) begin : g_bad_width
    $error("multiply_and_add: WEIGHT_WIDTH must not exceed DATA_WIDTH");
  end

  logic                 carry;
  logic [ACC_WIDTH-1:0] output_value_d;
  logic                 overflow_d;
  logic                 out_valid_d;
  logic                 out_valid_q;

  mac_comb #(
    .DATA_WIDTH   (DATA_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac_comb (
    .add_value    (add_value),
    .input_value  (input_value),
    .weight_value (weight_value),
    .sum          (output_value),
    .carry        (carry)
  );

  // Result and overflow are captured only for qualified operands; otherwise they hold.
  always_comb begin
    out_valid_d    = in_valid;
    output_value_d = output_value_q;
    overflow_d     = overflow_q;
    if (in_valid) begin
      output_value_d = output_value;
      overflow_d     = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      output_value_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      output_value_q <= output_value_d;
      overflow_q     <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiply_and_add.sv
module tb_multiply_and_add;

  logic        clk;
  logic        rst_n;
  logic [15:0] add_value;
  logic [7:0]  input_value;
  logic [7:0]  weight_value;
  logic        in_valid;
  logic [15:0] output_value;
  logic        out_valid;
  logic [15:0] output_value_q;
  logic        overflow_q;

  int checks = 0;
  int errors = 0;

  multiply_and_add dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .add_value      (add_value),
    .input_value    (input_value),
    .weight_value   (weight_value),
    .in_valid       (in_valid),
    .output_value   (output_value),
    .out_valid      (out_valid),
    .output_value_q (output_value_q),
    .overflow_q     (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; add_value = '0; input_value = '0; weight_value = '0; in_valid = 1'b0;
    #3;
    checks++;
    if (output_value !== 16'd0) begin
      errors++; $display("FAIL reset_comb: got %0d expected 0", output_value);
    end
    checks++;
    if (out_valid !== 1'b0 || output_value_q !== 16'd0 || overflow_q !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got v=%b q=%0d ovf=%b expected 0/0/0",
                         out_valid, output_value_q, overflow_q);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || output_value_q !== 16'd0 || overflow_q !== 1'b0) begin
      errors++; $display("FAIL release_regs: got v=%b q=%0d ovf=%b expected 0/0/0",
                         out_valid, output_value_q, overflow_q);
    end
  endtask

  task automatic test_zero_operands();
    @(negedge clk);
    add_value = 16'd1; input_value = 8'd0; weight_value = 8'd0; #1;
    checks++;
    if (output_value !== 16'd1) begin
      errors++; $display("FAIL zero_both: got %0d expected 1", output_value);
    end
    input_value = 8'd2; #1;
    checks++;
    if (output_value !== 16'd1) begin
      errors++; $display("FAIL zero_weight: got %0d expected 1", output_value);
    end
    weight_value = 8'd3; #1;
    checks++;
    if (output_value !== 16'd7) begin
      errors++; $display("FAIL comb_no_clock: got %0d expected 7", output_value);
    end
    input_value = 8'd0; #1;
    checks++;
    if (output_value !== 16'd1) begin
      errors++; $display("FAIL zero_input: got %0d expected 1", output_value);
    end
  endtask

  task automatic test_single_op();
    @(negedge clk);
    add_value = 16'd10; input_value = 8'd5; weight_value = 8'd2; in_valid = 1'b1; #1;
    checks++;
    if (output_value !== 16'd20) begin
      errors++; $display("FAIL single_comb: got %0d expected 20", output_value);
    end
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd20 || out_valid !== 1'b1 || overflow_q !== 1'b0) begin
      errors++; $display("FAIL single_reg: got q=%0d v=%b ovf=%b expected 20/1/0",
                         output_value_q, out_valid, overflow_q);
    end
    @(negedge clk);
    in_valid = 1'b0; add_value = 16'd99;
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd20 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_hold: got q=%0d v=%b expected 20/0",
                         output_value_q, out_valid);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    add_value = 16'hFFFF; input_value = 8'd1; weight_value = 8'd1; in_valid = 1'b1; #1;
    checks++;
    if (output_value !== 16'd0) begin
      errors++; $display("FAIL wrap_comb: got %0d expected 0", output_value);
    end
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd0 || overflow_q !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_reg: got q=%0d ovf=%b v=%b expected 0/1/1",
                         output_value_q, overflow_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0; add_value = 16'd3;
    @(posedge clk); #1;
    checks++;
    if (overflow_q !== 1'b1 || output_value_q !== 16'd0) begin
      errors++; $display("FAIL wrap_hold: got ovf=%b q=%0d expected 1/0",
                         overflow_q, output_value_q);
    end
  endtask

  task automatic test_max_product();
    @(negedge clk);
    add_value = 16'd0; input_value = 8'd255; weight_value = 8'd255; in_valid = 1'b1; #1;
    checks++;
    if (output_value !== 16'd65025) begin
      errors++; $display("FAIL maxprod_comb: got %0d expected 65025", output_value);
    end
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd65025 || overflow_q !== 1'b0) begin
      errors++; $display("FAIL maxprod_reg: got q=%0d ovf=%b expected 65025/0",
                         output_value_q, overflow_q);
    end
    @(negedge clk);
    add_value = 16'd511; #1;
    checks++;
    if (output_value !== 16'd0) begin
      errors++; $display("FAIL maxprod_wrap_comb: got %0d expected 0", output_value);
    end
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd0 || overflow_q !== 1'b1) begin
      errors++; $display("FAIL maxprod_wrap_reg: got q=%0d ovf=%b expected 0/1",
                         output_value_q, overflow_q);
    end
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk);
    add_value = 16'd100; input_value = 8'd3; weight_value = 8'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd112 || out_valid !== 1'b1) begin
      errors++; $display("FAIL stream_first: got q=%0d v=%b expected 112/1",
                         output_value_q, out_valid);
    end
    add_value = 16'hFFF0; input_value = 8'd7; weight_value = 8'd9;
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd47 || overflow_q !== 1'b1) begin
      errors++; $display("FAIL stream_second: got q=%0d ovf=%b expected 47/1",
                         output_value_q, overflow_q);
    end
    add_value = 16'd200; #1;
    rst_n = 1'b0; #1;
    checks++;
    if (output_value_q !== 16'd0 || out_valid !== 1'b0 || overflow_q !== 1'b0) begin
      errors++; $display("FAIL async_clear: got q=%0d v=%b ovf=%b expected 0/0/0",
                         output_value_q, out_valid, overflow_q);
    end
    checks++;
    if (output_value !== 16'd263) begin
      errors++; $display("FAIL comb_in_reset: got %0d expected 263", output_value);
    end
    add_value = 16'd1; input_value = 8'd2; weight_value = 8'd2; #1;
    checks++;
    if (output_value !== 16'd5) begin
      errors++; $display("FAIL comb_track_reset: got %0d expected 5", output_value);
    end
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL held_in_reset: got q=%0d v=%b expected 0/0",
                         output_value_q, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    add_value = 16'd50; input_value = 8'd10; weight_value = 8'd10;
    @(posedge clk); #1;
    checks++;
    if (output_value_q !== 16'd150 || out_valid !== 1'b1 || overflow_q !== 1'b0) begin
      errors++; $display("FAIL after_release: got q=%0d v=%b ovf=%b expected 150/1/0",
                         output_value_q, out_valid, overflow_q);
    end
  endtask

  initial begin
    test_reset();
    test_zero_operands();
    test_single_op();
    test_wrap();
    test_max_product();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
